// File: rtl/combo_lock_pkg.sv
// Shared types and helpers for the parametrised combination lock.
package combo_lock_pkg;
  localparam int CODE_MAX_W  = 64;
  localparam int DIGIT_MAX_W = 16;

  typedef enum logic [2:0] {
    CLOSED  = 3'd0,
    OPEN    = 3'd1,
    ERROR   = 3'd2,
    FAILED  = 3'd3,
    LOCKOUT = 3'd4,
    PROGRAM = 3'd5
  } lock_status_e;

  // Field idx of an n_digits code; field 0 is the first-entered (most significant) digit.
  function automatic logic [DIGIT_MAX_W-1:0] digit_field(input logic [CODE_MAX_W-1:0] code,
                                                         input int idx, input int n_digits,
                                                         input int digit_w);
    logic [CODE_MAX_W-1:0]  sh;
    logic [DIGIT_MAX_W-1:0] mask;
    sh   = code >> ((n_digits - 1 - idx) * digit_w);
    mask = (DIGIT_MAX_W'(1) << digit_w) - DIGIT_MAX_W'(1);
    return sh[DIGIT_MAX_W-1:0] & mask;
  endfunction
endpackage

// File: rtl/param_combo_lock_if.sv
// Key-entry strobes in, lock status out.
interface param_combo_lock_if
  import combo_lock_pkg::*;
#(
  parameter int N_DIGITS = 6,
  parameter int DIGIT_W  = 4
);
  logic                            digit_valid;
  logic [DIGIT_W-1:0]              digit;
  logic                            relock;
  logic                            prog_en;
  lock_status_e                    status;
  logic [$clog2(N_DIGITS+1)-1:0]   digits_entered;
  logic [3:0]                      fail_count;
  logic                            open;

  modport master (output digit_valid, digit, relock, prog_en,
                  input  status, digits_entered, fail_count, open);
  modport slave  (input  digit_valid, digit, relock, prog_en,
                  output status, digits_entered, fail_count, open);
endinterface

// File: rtl/param_combo_lock_lockout_timer.sv
// Down-counter for the lockout hold-off; zero_o flags expiry.
module lockout_timer #(
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);
  localparam int TW = $clog2(LOCKOUT_CYCLES) + 1;

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      cnt_q <= '0;
    else if (load_i)                  cnt_q <= TW'(LOCKOUT_CYCLES - 1);
    else if (dec_i && cnt_q != '0)    cnt_q <= cnt_q - TW'(1);
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/param_combo_lock.sv
// Combination lock with fail counter, timed lockout and run-time programmable code.
module param_combo_lock
  import combo_lock_pkg::*;
#(
  parameter int                          N_DIGITS       = 6,
  parameter int                          DIGIT_W        = 4,
  parameter int                          MAX_DIGIT      = 9,
  parameter logic [N_DIGITS*DIGIT_W-1:0] DEFAULT_CODE   = 24'h797773,
  parameter int                          MAX_TRIES      = 3,
  parameter int                          LOCKOUT_CYCLES = 16
) (
  input logic               clk_i,
  input logic               rst_ni,
  param_combo_lock_if.slave bus
);
  localparam int CODE_W = N_DIGITS * DIGIT_W;
  localparam int CW     = $clog2(N_DIGITS + 1);

  lock_status_e      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        fail_q, fail_d;
  logic              mism_q, mism_d;
  logic [CODE_W-1:0] code_q, code_d, shadow_q, shadow_d;
  logic              tmr_load, tmr_dec, tmr_zero;
  logic              legal, last, mm;

  assign legal = (bus.digit <= DIGIT_W'(MAX_DIGIT));
  assign last  = (cnt_q == CW'(N_DIGITS - 1));
  // Sticky mismatch including the digit presented this cycle.
  assign mm    = mism_q | (digit_field(CODE_MAX_W'(code_q), int'(cnt_q), N_DIGITS, DIGIT_W)
                           != DIGIT_MAX_W'(bus.digit));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fail_d   = fail_q;
    mism_d   = mism_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      CLOSED: begin
        if (bus.relock) begin
          cnt_d  = '0;
          mism_d = 1'b0;
        end else if (bus.digit_valid) begin
          if (!legal) begin
            state_d = ERROR;
          end else if (last) begin
            cnt_d  = '0;
            mism_d = 1'b0;
            if (!mm) begin
              state_d = OPEN;
              fail_d  = '0;
            end else begin
              fail_d = (fail_q == 4'(MAX_TRIES)) ? fail_q : fail_q + 4'd1;
              if (fail_d == 4'(MAX_TRIES)) begin
                state_d  = LOCKOUT;
                tmr_load = 1'b1;
              end else begin
                state_d = FAILED;
              end
            end
          end else begin
            cnt_d  = cnt_q + CW'(1);
            mism_d = mm;
          end
        end
      end
      ERROR, FAILED: begin
        if (bus.relock) begin
          state_d = CLOSED;
          cnt_d   = '0;
          mism_d  = 1'b0;
        end
      end
      LOCKOUT: begin
        if (tmr_zero) begin
          state_d = CLOSED;
          fail_d  = '0;
          cnt_d   = '0;
          mism_d  = 1'b0;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      OPEN: begin
        if (bus.relock) begin
          state_d = CLOSED;
          cnt_d   = '0;
          mism_d  = 1'b0;
        end else if (bus.prog_en) begin
          state_d  = PROGRAM;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      PROGRAM: begin
        if (bus.relock) begin
          state_d = CLOSED;
          cnt_d   = '0;
          mism_d  = 1'b0;
        end else if (bus.digit_valid) begin
          if (!legal) begin
            state_d = OPEN;
            cnt_d   = '0;
          end else begin
            shadow_d[(N_DIGITS - 1 - int'(cnt_q)) * DIGIT_W +: DIGIT_W] = bus.digit;
            if (last) begin
              code_d  = shadow_d;
              state_d = OPEN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
      default: state_d = CLOSED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= CLOSED;
      cnt_q    <= '0;
      fail_q   <= '0;
      mism_q   <= 1'b0;
      code_q   <= DEFAULT_CODE;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fail_q   <= fail_d;
      mism_q   <= mism_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
    end
  end

  lockout_timer #(.LOCKOUT_CYCLES(LOCKOUT_CYCLES)) u_tmr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (tmr_load),
    .dec_i  (tmr_dec),
    .zero_o (tmr_zero)
  );

  assign bus.status         = state_q;
  assign bus.digits_entered = cnt_q;
  assign bus.fail_count     = fail_q;
  assign bus.open           = (state_q == OPEN);
endmodule

// File: tb/tb_param_combo_lock.sv
// Directed plus randomized checks of param_combo_lock against a queue-based model.
module tb_param_combo_lock;
  import combo_lock_pkg::*;

  localparam int N = 6, W = 4, MAXD = 9, TRIES = 3, LCYC = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  param_combo_lock_if #(.N_DIGITS(N), .DIGIT_W(W)) bus ();

  param_combo_lock #(
    .N_DIGITS(N), .DIGIT_W(W), .MAX_DIGIT(MAXD), .DEFAULT_CODE(24'h797773),
    .MAX_TRIES(TRIES), .LOCKOUT_CYCLES(LCYC)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: entered digits kept in a queue and compared whole at completion.
  lock_status_e m_st;
  int m_fail, m_tmr;
  int m_code[N];
  int m_ent[$];

  task automatic m_reset();
    m_st = CLOSED; m_fail = 0; m_tmr = 0;
    m_ent.delete();
    m_code = '{7, 9, 7, 7, 7, 3};
  endtask

  task automatic m_step(input bit dv, input int d, input bit rl, input bit pe);
    bit ok;
    case (m_st)
      CLOSED:
        if (rl) m_ent.delete();
        else if (dv) begin
          if (d > MAXD) m_st = ERROR;
          else begin
            m_ent.push_back(d);
            if (m_ent.size() == N) begin
              ok = 1'b1;
              for (int i = 0; i < N; i++) if (m_ent[i] != m_code[i]) ok = 1'b0;
              m_ent.delete();
              if (ok) begin m_st = OPEN; m_fail = 0; end
              else begin
                if (m_fail < TRIES) m_fail++;
                if (m_fail == TRIES) begin m_st = LOCKOUT; m_tmr = LCYC; end
                else m_st = FAILED;
              end
            end
          end
        end
      ERROR, FAILED: if (rl) begin m_st = CLOSED; m_ent.delete(); end
      LOCKOUT: begin
        m_tmr--;
        if (m_tmr == 0) begin m_st = CLOSED; m_fail = 0; m_ent.delete(); end
      end
      OPEN:
        if (rl) begin m_st = CLOSED; m_ent.delete(); end
        else if (pe) begin m_st = PROGRAM; m_ent.delete(); end
      PROGRAM:
        if (rl) begin m_st = CLOSED; m_ent.delete(); end
        else if (dv) begin
          if (d > MAXD) begin m_st = OPEN; m_ent.delete(); end
          else begin
            m_ent.push_back(d);
            if (m_ent.size() == N) begin
              for (int i = 0; i < N; i++) m_code[i] = m_ent[i];
              m_st = OPEN;
              m_ent.delete();
            end
          end
        end
      default: m_st = CLOSED;
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".status"}, int'(bus.status), int'(m_st));
    chk({tag, ".digits"}, int'(bus.digits_entered), m_ent.size());
    chk({tag, ".fails"},  int'(bus.fail_count), m_fail);
    chk({tag, ".open"},   int'(bus.open), (m_st == OPEN) ? 1 : 0);
  endtask

  // Called at a negedge: drive, clock, advance model, check at next negedge.
  task automatic cyc(input bit dv, input int d, input bit rl, input bit pe, input string tag);
    bus.digit_valid = dv;
    bus.digit       = 4'(d);
    bus.relock      = rl;
    bus.prog_en     = pe;
    @(posedge clk);
    m_step(dv, d, rl, pe);
    @(negedge clk);
    bus.digit_valid = 1'b0;
    bus.relock      = 1'b0;
    bus.prog_en     = 1'b0;
    check_all(tag);
  endtask

  task automatic enter(input logic [23:0] code, input string tag);
    logic [23:0] c;
    c = code;
    for (int i = 0; i < N; i++) cyc(1'b1, int'(c[23-4*i -: 4]), 1'b0, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    m_reset();
    #1 check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.digit_valid = 1'b0; bus.digit = '0; bus.relock = 1'b0; bus.prog_en = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    enter(24'h797773, "good");
    chk("good_open", int'(bus.status), int'(OPEN));

    cyc(0, 0, 1, 0, "relock_open");
    enter(24'h793235, "bad");
    chk("bad_failed", int'(bus.status), int'(FAILED));
    chk("bad_fail1", int'(bus.fail_count), 1);
    cyc(0, 0, 1, 0, "relock_failed");
    chk("relock_closed", int'(bus.status), int'(CLOSED));

    cyc(1, 15, 0, 0, "illegal");
    chk("illegal_error", int'(bus.status), int'(ERROR));
    cyc(0, 0, 1, 0, "relock_error");

    do_reset("rst_pre_lock");
    for (int k = 0; k < TRIES; k++) begin
      enter(24'h111111, "wrong");
      if (k < TRIES - 1) cyc(0, 0, 1, 0, "relock_wrong");
    end
    chk("lockout_enter", int'(bus.status), int'(LOCKOUT));
    for (int k = 0; k < LCYC; k++)
      cyc($urandom_range(0, 1), $urandom_range(0, 15), 1'b1, $urandom_range(0, 1), "lockout");
    chk("lockout_exit", int'(bus.status), int'(CLOSED));
    chk("lockout_fail0", int'(bus.fail_count), 0);

    enter(24'h797773, "pre_prog");
    cyc(0, 0, 0, 1, "prog_en");
    chk("prog_state", int'(bus.status), int'(PROGRAM));
    enter(24'h123456, "prog");
    chk("prog_done", int'(bus.status), int'(OPEN));
    cyc(0, 0, 1, 0, "relock_p");
    enter(24'h123456, "newcode");
    chk("newcode_open", int'(bus.status), int'(OPEN));
    cyc(0, 0, 1, 0, "relock_p2");
    enter(24'h797773, "oldcode");
    chk("oldcode_failed", int'(bus.status), int'(FAILED));
    cyc(0, 0, 1, 0, "relock_p3");
    enter(24'h123456, "newcode2");
    cyc(0, 0, 0, 1, "prog_en2");
    cyc(1, 1, 0, 0, "abort");
    cyc(1, 2, 0, 0, "abort");
    cyc(1, 15, 0, 0, "abort");
    chk("abort_open", int'(bus.status), int'(OPEN));
    cyc(0, 0, 1, 0, "relock_p4");
    enter(24'h123456, "kept");
    chk("kept_open", int'(bus.status), int'(OPEN));

    cyc(0, 0, 1, 0, "relock_r");
    for (int i = 0; i < 3; i++) cyc(1, 7, 0, 0, "mid_entry");
    do_reset("rst_mid_entry");
    cyc(0, 0, 0, 1, "prog_closed");
    enter(24'h123456, "post_rst_new");
    chk("post_rst_new_failed", int'(bus.status), int'(FAILED));
    cyc(0, 0, 1, 0, "relock_r2");
    enter(24'h797773, "post_rst_def");
    chk("post_rst_def_open", int'(bus.status), int'(OPEN));
    cyc(0, 0, 0, 1, "prog_en3");
    cyc(1, 5, 0, 0, "mid_prog");
    cyc(1, 5, 0, 0, "mid_prog");
    do_reset("rst_mid_prog");
    enter(24'h797773, "post_prog_rst");
    chk("post_prog_rst_open", int'(bus.status), int'(OPEN));

    // Random traffic, biased toward the current correct digit so OPEN/PROGRAM get visited.
    for (int k = 0; k < 3000; k++) begin
      bit dv, rl, pe;
      int d;
      dv = ($urandom_range(0, 99) < 60);
      rl = ($urandom_range(0, 99) < 4);
      pe = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 19) == 0) d = $urandom_range(MAXD + 1, 15);
      else if (m_st == CLOSED && $urandom_range(0, 3) != 0) d = m_code[m_ent.size()];
      else d = $urandom_range(0, MAXD);
      cyc(dv, d, rl, pe, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
